// File: rtl/imm_chunk_encoder_pkg.sv
// Shared types, default widths and the chunk-count helper for the immediate chunk encoder.
`default_nettype none

package imm_chunk_encoder_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_CHUNK_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

    // Smallest k such that val fits in k*chunk_w signed bits; max_chunks always fits.
    function automatic int unsigned chunks_needed(input longint val,
                                                  input int unsigned chunk_w,
                                                  input int unsigned max_chunks);
        int unsigned k;
        longint      lim;
        k = max_chunks;
        for (int i = int'(max_chunks) - 1; i >= 1; i--) begin
            lim = longint'(1) <<< (i * int'(chunk_w) - 1);
            if (val >= -lim && val < lim) begin
                k = int'(i);
            end
        end
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_chunk_encoder_classifier.sv
// Combinational range classifier: maps a signed word to (number of chunks - 1).
`default_nettype none

module imm_range_classifier
    import imm_chunk_encoder_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CHUNK_W = DEFAULT_CHUNK_W
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [1:0]        k_m1_o
);

    localparam int MAX_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W;

    int unsigned w_k;

    always_comb begin
        w_k    = chunks_needed(longint'(signed'(data_i)), CHUNK_W, MAX_CHUNKS);
        k_m1_o = 2'(w_k - 1);
    end

endmodule

`default_nettype wire

// File: rtl/imm_chunk_encoder.sv
// Splits a signed word into the minimum number of signed chunks, MSB chunk first.
// Optional statistics counters are enabled by defining IMM_ENC_STATS_EN.
`default_nettype none

module imm_chunk_encoder
    import imm_chunk_encoder_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CHUNK_W = DEFAULT_CHUNK_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [CHUNK_W-1:0] out_chunk,
    output logic               out_first,
    output logic               out_last,
    output logic [1:0]         out_count,
    input  logic               out_ready
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [15:0]        stat_words,
    output logic [15:0]        stat_multi
`endif
);

    localparam int MAX_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int EXT_W      = MAX_CHUNKS * CHUNK_W;

    enc_state_t       state_q, state_d;
    logic [EXT_W-1:0] word_q, word_d;
    logic [1:0]       k_q, k_d;
    logic [1:0]       idx_q, idx_d;

    logic [1:0]              w_k_m1;
    logic [EXT_W+DATA_W-1:0] w_wide;
    logic [EXT_W-1:0]        w_ext;
    logic [EXT_W-1:0]        w_sel;

    imm_range_classifier #(
        .DATA_W  (DATA_W),
        .CHUNK_W (CHUNK_W)
    ) u_classifier (
        .data_i (in_data),
        .k_m1_o (w_k_m1)
    );

    assign w_wide = {{EXT_W{in_data[DATA_W-1]}}, in_data};
    assign w_ext  = w_wide[EXT_W-1:0];
    // Chunk idx sits (k-1-idx) chunk positions above bit 0 of the extended word.
    assign w_sel  = word_q >> (CHUNK_W * int'(k_q - idx_q));

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        k_d       = k_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_count = 2'd0;
        out_chunk = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = EMIT;
                    word_d  = w_ext;
                    k_d     = w_k_m1;
                    idx_d   = 2'd0;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_first = (idx_q == 2'd0);
                out_last  = (idx_q == k_q);
                out_count = k_q;
                out_chunk = w_sel[CHUNK_W-1:0];
                if (out_ready) begin
                    if (idx_q == k_q) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            k_q     <= 2'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
        end
    end

`ifdef IMM_ENC_STATS_EN
    logic [15:0] words_q;
    logic [15:0] multi_q;
    logic        w_accept;

    assign w_accept   = in_valid && in_ready;
    assign stat_words = words_q;
    assign stat_multi = multi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_q <= 16'd0;
            multi_q <= 16'd0;
        end else if (w_accept) begin
            if (words_q != 16'hFFFF) begin
                words_q <= words_q + 16'd1;
            end
            if (w_k_m1 != 2'd0 && multi_q != 16'hFFFF) begin
                multi_q <= multi_q + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_chunk_encoder.sv
// Scoreboard bench for imm_chunk_encoder at default parameters.
`default_nettype none

module tb_imm_chunk_encoder;

    typedef struct packed {
        logic [4:0] chunk;
        logic       first;
        logic       last;
        logic [1:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  out_chunk;
    logic        out_first;
    logic        out_last;
    logic [1:0]  out_count;
    logic        out_ready = 1'b1;
`ifdef IMM_ENC_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_multi;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    imm_chunk_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_chunk (out_chunk),
        .out_first (out_first),
        .out_last  (out_last),
        .out_count (out_count),
        .out_ready (out_ready)
`ifdef IMM_ENC_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_multi(stat_multi)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_k(input logic [15:0] w);
        int v;
        v = int'($signed(w));
        if (v >= -16 && v <= 15) return 1;
        if (v >= -512 && v <= 511) return 2;
        if (v >= -16384 && v <= 16383) return 3;
        return 4;
    endfunction

    task automatic push_word(input logic [15:0] w);
        logic [19:0] ext;
        int          k;
        exp_t        e;
        ext = {{4{w[15]}}, w};
        k   = exp_k(w);
        for (int j = 0; j < k; j++) begin
            e.chunk = ext[5*(k-j)-1 -: 5];
            e.first = (j == 0);
            e.last  = (j == k - 1);
            e.count = 2'(k - 1);
            sb.push_back(e);
        end
    endtask

    // Offers one word, then consumes its chunks; optional stall on one chunk or reset abort.
    task automatic run_word(input logic [15:0] w, input int stall_idx, input int stall_n,
                            input int abort_at);
        exp_t e;
        int   idx;
        int   cycles;
        int   acc;
        chk("in_ready_before", 32'(in_ready), 32'd1);
        push_word(w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = 16'($urandom);
        out_ready = 1'b1;
        idx       = 0;
        cycles    = 0;
        acc       = 0;
        while (sb.size() > 0 && cycles < 40) begin
            cycles++;
            if (!out_valid) begin
                @(posedge clk);
                #1;
                continue;
            end
            e = sb.pop_front();
            chk("chunk", 32'(out_chunk), 32'(e.chunk));
            chk("first", 32'(out_first), 32'(e.first));
            chk("last",  32'(out_last),  32'(e.last));
            chk("count", 32'(out_count), 32'(e.count));
            if (e.first) acc = int'($signed(out_chunk));
            else         acc = (acc <<< 5) | int'(out_chunk);
            if (idx == stall_idx) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_chunk", 32'(out_chunk), 32'(e.chunk));
                    chk("stall_flags", {30'd0, out_first, out_last}, {30'd0, e.first, e.last});
                    chk("stall_count", 32'(out_count), 32'(e.count));
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            idx++;
            if (idx == abort_at) begin
                reset = 1'b1;
                #2;
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_in_ready",  32'(in_ready),  32'd1);
                chk("rst_outs", {out_chunk, out_first, out_last, out_count}, 32'd0);
                @(posedge clk);
                #1;
                chk("rst_hold_valid", 32'(out_valid), 32'd0);
                reset = 1'b0;
                sb.delete();
                return;
            end
        end
        if (sb.size() != 0) begin
            chk("timeout_left", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        chk("decode", 32'(acc), 32'(int'($signed(w))));
        chk("idle_gap_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] words[$];
        words = '{16'h000A, 16'hFFFA, 16'h0010, 16'h8000, 16'h000F, 16'hFFF0,
                  16'h0011, 16'hFFEF, 16'h01FF, 16'hFE00, 16'h0200, 16'hFDFF,
                  16'h3FFF, 16'hC000, 16'h4000, 16'hBFFF, 16'h7FFF, 16'h0000};
        #2;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outs", {out_chunk, out_first, out_last, out_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_word(16'h1234, 1, 3, -1);
        @(posedge clk);
        #1;
        foreach (words[i]) run_word(words[i], -1, 0, -1);
        for (int i = 0; i < 8; i++) run_word(16'($urandom), int'($urandom_range(0, 3)), 2, -1);
        run_word(16'h8000, -1, 0, 2);
        run_word(16'h000A, -1, 0, -1);
`ifdef IMM_ENC_STATS_EN
        chk("stat_words", 32'(stat_words), 32'd1);
        chk("stat_multi", 32'(stat_multi), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
